// File: rtl/fc_neuron.sv
// fc_neuron: single fully-connected output neuron.
//
// Forms the signed dot product of eight pooled pixels and eight weights,
// saturates it to a signed 8-bit score (optionally clamped at zero) and
// registers it. Every clock edge is an independent evaluation with one cycle
// of latency; there is no handshake and no state besides the output register.
//
// Parameters:
//   RELU_EN           1 = clamp negative scores to zero before registering.
// Ports:
//   clk               rising-edge clock.
//   rst               synchronous active-high reset; forces result to 8'h00.
//   pooledPixelArray  eight signed 8-bit pixels; [63:32] kernel map 0,
//                     [31:0] kernel map 1.
//   weight            eight signed 8-bit weights, same byte layout.
//   result            registered signed 8-bit score.
module fc_neuron #(
    parameter int unsigned RELU_EN = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pooledPixelArray,
    input  logic [63:0] weight,
    output logic [7:0]  result
);

    localparam int unsigned SumW = 20;

    logic signed [15:0]     prod [8];
    logic signed [SumW-1:0] sum;
    logic [7:0]             score;
    logic [7:0]             result_q;

    // Byte i of pixels pairs only with byte i of weights.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            prod[i] = $signed(pooledPixelArray[8*i +: 8]) * $signed(weight[8*i +: 8]);
            sum     = sum + {{(SumW-16){prod[i][15]}}, prod[i]};
        end
    end

    always_comb begin
        if (sum > 20'sd127) begin
            score = 8'h7f;
        end else if (sum < -20'sd128) begin
            score = 8'h80;
        end else begin
            score = sum[7:0];
        end
        if ((RELU_EN != 0) && score[7]) begin
            score = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 8'h00;
        end else begin
            result_q <= score;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_fc_neuron.sv
module tb_fc_neuron;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pix;
    logic [63:0] wt;
    logic [7:0]  res0;
    logic [7:0]  res1;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp0;
    logic [7:0] exp1;
    bit         exp_valid = 1'b0;

    localparam logic [63:0] XP = 64'h01ffff01_ff0101ff;
    localparam logic [63:0] OP = 64'hff0101ff_01ffff01;
    localparam logic [63:0] AP = 64'hffffffff_ff0101ff;
    localparam logic [63:0] BP = 64'h01ffff01_ffffffff;

    always #5 clk = ~clk;

    fc_neuron #(.RELU_EN(0)) dut0 (
        .clk              (clk),
        .rst              (rst),
        .pooledPixelArray (pix),
        .weight           (wt),
        .result           (res0)
    );

    fc_neuron #(.RELU_EN(1)) dut1 (
        .clk              (clk),
        .rst              (rst),
        .pooledPixelArray (pix),
        .weight           (wt),
        .result           (res1)
    );

    // Reference: plain integer dot product, clamp, optional ReLU.
    function automatic int dot(input logic [63:0] p, input logic [63:0] w);
        int s = 0;
        for (int i = 0; i < 8; i++) begin
            byte pb;
            byte wb;
            pb = p[8*i +: 8];
            wb = w[8*i +: 8];
            s += int'(pb) * int'(wb);
        end
        return s;
    endfunction

    function automatic logic [7:0] score(input logic [63:0] p, input logic [63:0] w,
                                         input bit relu);
        int s;
        s = dot(p, w);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        if (relu && s < 0) s = 0;
        return 8'(s);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model register: what result must hold after each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            exp0      <= 8'h00;
            exp1      <= 8'h00;
            exp_valid <= 1'b1;
        end else begin
            exp0 <= score(pix, wt, 1'b0);
            exp1 <= score(pix, wt, 1'b1);
        end
    end

    always @(negedge clk) begin
        if (exp_valid) begin
            check("model_relu0", res0, exp0);
            check("model_relu1", res1, exp1);
        end
    end

    // Drive inputs, let one rising edge sample them, return at the next negedge.
    task automatic step(input logic [63:0] p, input logic [63:0] w, input logic r);
        pix = p;
        wt  = w;
        rst = r;
        @(negedge clk);
    endtask

    logic [63:0] wts [4];
    logic [63:0] pxs [3];

    initial begin
        wts = '{XP, OP, AP, BP};
        pxs = '{OP, AP, BP};

        // Pin the model against hand-computed values.
        check("pin_x",    score(XP, XP, 1'b0), 8'h08);
        check("pin_o",    score(XP, OP, 1'b0), 8'hf8);
        check("pin_sat+", score({8{8'h80}}, {8{8'h80}}, 1'b0), 8'h7f);
        check("pin_sat-", score({8{8'h7f}}, {8{8'h80}}, 1'b0), 8'h80);
        check("pin_relu", score(XP, OP, 1'b1), 8'h00);

        // Reset with arbitrary inputs.
        pix = {$urandom, $urandom};
        wt  = {$urandom, $urandom};
        rst = 1'b1;
        @(negedge clk);
        step({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        check("reset0", res0, 8'h00);
        check("reset1", res1, 8'h00);

        // X-pixel sweep.
        step(XP, XP, 1'b0);
        check("x_x", res0, 8'h08);
        check("x_x_relu", res1, 8'h08);
        step(XP, OP, 1'b0);
        check("x_o", res0, 8'hf8);
        check("x_o_relu", res1, 8'h00);
        step(XP, AP, 1'b0);
        check("x_a", res0, 8'h04);
        step(XP, BP, 1'b0);
        check("x_b", res0, 8'h04);

        // Template rotation.
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                step(pxs[k], wts[j], 1'b0);
                if (pxs[k] == wts[j]) check("rot_match", res0, 8'h08);
            end
        end

        // Saturation.
        step({8{8'h80}}, {8{8'h80}}, 1'b0);
        check("sat_pos", res0, 8'h7f);
        step({8{8'h7f}}, {8{8'h80}}, 1'b0);
        check("sat_neg", res0, 8'h80);
        step({8{8'h10}}, {8{8'h01}}, 1'b0);
        check("sat_128", res0, 8'h7f);
        step({{7{8'h10}}, 8'h0f}, {8{8'h01}}, 1'b0);
        check("edge_127", res0, 8'h7f);

        // Lane isolation.
        for (int i = 0; i < 8; i++) begin
            logic [63:0] p;
            logic [63:0] w;
            p = 64'h05 << (8*i);
            w = 64'hfd << (8*i);
            step(p, w, 1'b0);
            check("lane", res0, 8'hf1);
        end

        // Reset mid-stream discards the in-flight value.
        step({8{8'h80}}, {8{8'h80}}, 1'b1);
        check("mid_reset", res0, 8'h00);
        step(XP, XP, 1'b0);
        check("post_reset", res0, 8'h08);

        // Random stimulus against the model, biased towards small magnitudes too.
        for (int n = 0; n < 400; n++) begin
            logic [63:0] p;
            logic [63:0] w;
            p = {$urandom, $urandom};
            w = {$urandom, $urandom};
            if (n % 3 == 1) begin
                for (int i = 0; i < 8; i++) begin
                    p[8*i +: 8] = 8'($urandom_range(0, 6)) - 8'd3;
                    w[8*i +: 8] = 8'($urandom_range(0, 6)) - 8'd3;
                end
            end
            step(p, w, ($urandom_range(0, 24) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
